// File: rtl/dac_word_serializer_pkg.sv
// Shared definitions for the DAC command path: format codes, AD5449 command
// nibbles and the serializer state encoding.
package dac_word_serializer_pkg;

  typedef logic [11:0] dac_code_t;
  typedef logic [1:0]  dac_fmt_t;
  typedef logic [15:0] dac_frame_t;

  localparam dac_fmt_t DAC7311_FORMAT  = 2'h0;
  localparam dac_fmt_t AD5449_FORMAT_A = 2'h1;
  localparam dac_fmt_t AD5449_FORMAT_B = 2'h2;

  localparam logic [3:0] CMD_LOAD_A = 4'b0001;
  localparam logic [3:0] CMD_LOAD_B = 4'b0100;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/dac_word_serializer_if.sv
// Command-side handshake plus the serial data/clock/sync triple.
interface dac_word_serializer_if;
  import dac_word_serializer_pkg::*;

  logic       tx_start_strobe;
  dac_code_t  data_in;
  dac_fmt_t   data_format_option;
  logic       serial_data;
  logic       serial_clk;
  logic       sync;
  logic       busy;

  modport master (
    output tx_start_strobe, data_in, data_format_option,
    input  serial_data, serial_clk, sync, busy
  );

  modport slave (
    input  tx_start_strobe, data_in, data_format_option,
    output serial_data, serial_clk, sync, busy
  );
endinterface

// File: rtl/dac_word_format.sv
// Combinational 12-bit code to 16-bit device frame builder.
module dac_word_format
  import dac_word_serializer_pkg::*;
#(
  parameter logic [3:0] CMD_A = CMD_LOAD_A,
  parameter logic [3:0] CMD_B = CMD_LOAD_B
) (
  input  dac_code_t  data_i,
  input  dac_fmt_t   fmt_i,
  output dac_frame_t frame_o
);

  // The reserved code falls through to the DAC7311 layout.
  always_comb begin
    case (fmt_i)
      AD5449_FORMAT_A: frame_o = {CMD_A, data_i};
      AD5449_FORMAT_B: frame_o = {CMD_B, data_i};
      default:         frame_o = {2'b00, data_i, 2'b00};
    endcase
  end

endmodule

// File: rtl/dac_word_serializer.sv
// MSB-first 16-bit frame transmitter; every pin comes straight from a flop.
module dac_word_serializer
  import dac_word_serializer_pkg::*;
#(
  parameter int         HALF_PERIOD  = 4,
  parameter logic [3:0] AD5449_CMD_A = CMD_LOAD_A,
  parameter logic [3:0] AD5449_CMD_B = CMD_LOAD_B
) (
  input  logic                 xclk,
  input  logic                 reset,
  dac_word_serializer_if.slave bus
);

  localparam int             HCW     = $clog2(HALF_PERIOD) + 1;
  localparam logic [HCW-1:0] HC_LAST = HCW'(HALF_PERIOD - 1);

  logic [2:0]     state_q, state_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [3:0]     bcnt_q, bcnt_d;
  dac_frame_t     shreg_q, shreg_d;
  logic           sdata_q, sdata_d;
  logic           sclk_q, sclk_d;
  logic           sync_q, sync_d;
  logic           busy_q, busy_d;
  dac_frame_t     frame;
  logic           hc_last;

  dac_word_format #(.CMD_A(AD5449_CMD_A), .CMD_B(AD5449_CMD_B)) u_fmt (
    .data_i  (bus.data_in),
    .fmt_i   (bus.data_format_option),
    .frame_o (frame)
  );

  assign hc_last = (hcnt_q == HC_LAST);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    sdata_d = sdata_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    busy_d  = busy_q;
    if (state_q != ST_IDLE) hcnt_d = hc_last ? '0 : hcnt_q + HCW'(1);
    case (state_q)
      ST_IDLE: if (bus.tx_start_strobe) begin
        state_d = ST_SETUP;
        shreg_d = frame;
        sdata_d = frame[15];
        bcnt_d  = 4'hF;
        hcnt_d  = '0;
        sync_d  = 1'b0;
        busy_d  = 1'b1;
      end
      ST_SETUP: if (hc_last) state_d = ST_SHIFT;
      // serial_clk itself tells which half of the bit period we are in
      ST_SHIFT: if (hc_last) begin
        if (sclk_q) begin
          sclk_d = 1'b0;
        end else begin
          sclk_d = 1'b1;
          if (bcnt_q == 4'd0) begin
            state_d = ST_HOLD;
          end else begin
            bcnt_d  = bcnt_q - 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
            sdata_d = shreg_q[14];
          end
        end
      end
      ST_HOLD: if (hc_last) begin
        state_d = ST_GAP;
        sync_d  = 1'b1;
      end
      ST_GAP: if (hc_last) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sdata_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b1;
        sync_d  = 1'b1;
        busy_d  = 1'b0;
        sdata_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      sdata_q <= 1'b0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      sdata_q <= sdata_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.serial_data = sdata_q;
  assign bus.serial_clk  = sclk_q;
  assign bus.sync        = sync_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/dac_word_serializer.md
# dac_word_serializer

Serial transmitter directly downstream of the DAC command buffer. It accepts one 12-bit DAC value plus a format code per start strobe, builds the 16-bit device frame (DAC7311 or AD5449 channel A/B), and shifts it out MSB-first on a single data/clock/sync triple. The buffer multiplexes that triple onto the physical DAC pins and inverts it for the board.

## Interface
- HALF_PERIOD, 4: xclk cycles per serial-clock half period; legal range is ≥1.
- AD5449_CMD_A, 4'b0001: AD5449 control nibble for "load and update DAC A".
- AD5449_CMD_B, 4'b0100: AD5449 control nibble for "load and update DAC B".

Ports. One clock; reset is asynchronous and active-high.
- xclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_start_strobe  in  1  one-cycle request to start a transmission.
- data_in  in  12  DAC code.
- data_format_option  in  2  frame format: 0 DAC7311, 1 AD5449 A, 2 AD5449 B, 3 reserved.
- serial_data  out  1  frame bit, MSB first, non-inverted.
- serial_clk  out  1  serial clock, idles high, non-inverted.
- sync  out  1  frame sync, active low, non-inverted.
- busy  out  1  high from acceptance until the inter-frame gap ends.

## Operation
- Frame build happens at acceptance. data_in and data_format_option are latched into a 16-bit shift register:
  - Format 0: {2'b00, data_in, 2'b00}.
  - Format 1: {AD5449_CMD_A, data_in}.
  - Format 2: {AD5449_CMD_B, data_in}.
  - Format 3: treated exactly as format 0.
- A strobe is accepted only in IDLE. A strobe in any other state is ignored and has no side effects.
- State machine:
  - IDLE: sync=1, serial_clk=1, serial_data=0, busy=0. A strobe moves to SETUP.
  - SETUP: sync=0, serial_clk=1, serial_data=frame[15]. Lasts H cycles, then moves to SHIFT.
  - SHIFT: 16 bit periods of 2H cycles each. In each period serial_clk is 1 for H cycles, then 0 for H cycles. serial_data changes only at the start of a bit period. After bit 0's low half, moves to HOLD.
  - HOLD: sync=0, serial_clk=1. Lasts H cycles, then moves to GAP.
  - GAP: sync=1, serial_clk=1. Lasts H cycles, then returns to IDLE.
- The DAC samples on the falling edge of serial_clk. Data is stable for H cycles before each falling edge and for H cycles after it.
- Counters:
  - Half-period counter, width clog2(HALF_PERIOD)+1; it wraps at H-1.
  - 4-bit bit counter, 15 down to 0; the terminal condition is bit 0 at the end of its low half.
- Every output is driven directly from a flop, with no combinational decode on the pins.

## Timing
- Reset values: sync=1, serial_clk=1, serial_data=0, busy=0, state=IDLE, shift register=0, counters=0.
- Reset asserted mid-frame forces the reset values asynchronously. The partial frame is abandoned. After reset deasserts, no frame resumes.
- A strobe sampled at edge T produces busy=1 and sync=0 from T+1.
- Busy stays high for exactly 35·H cycles (H+32H+H+H). With H=4 that is 140 cycles.
- busy falls on the cycle the FSM enters IDLE. A strobe sampled on that same edge is accepted, so back-to-back frames are allowed.
- The first falling edge of serial_clk occurs 2H cycles after sync falls. The last falling edge occurs 2H cycles before sync rises.
- data_in and data_format_option may change freely after the accepting edge.
- The upstream handshake is satisfied by design: busy is guaranteed high the cycle after an accepted strobe and low before the next one can be accepted.

## Structure
- Shared package holds:
  - format codes DAC7311_FORMAT=2'h0, AD5449_FORMAT_A=2'h1, AD5449_FORMAT_B=2'h2;
  - AD5449 command nibbles;
  - the 3-bit state encoding.
- The format codes are already used by the command buffer, so both blocks import them.
- One natural sub-module: `dac_word_format`, a combinational 12-bit-to-16-bit frame builder selected by the format code. It is unit-testable on its own.

## Test plan
- H=4; strobe with data_in=12'hABC, format 0 -> 16 falling edges sample 0x2AF0; sync low for 136 cycles; busy high for 140 cycles.
- Format 1, data 12'h800 -> sampled frame 0x1800. Format 2, data 12'h800 -> 0x4800.
- Format 3, data 12'hFFF -> sampled frame 0x3FFC, identical to format 0.
- Second strobe at cycle 50 of a frame -> ignored; the frame is unchanged and busy still falls at 140. A strobe on the busy-falling edge -> a new frame starts, with sync low on the next cycle.
- Reset pulsed at bit 7 of a frame -> outputs return to idle values within the reset cycle; the FSM stays in IDLE until the next strobe.
- H=1 -> busy lasts 35 cycles; the serial_clk duty cycle is exactly 1:1 per bit.
